score_keeper: RTL and testbench

Score and rally-state keeper for the pong game, sitting directly upstream of the seven-segment display controller. It turns point events from the ball/paddle logic into two 2-digit BCD scores, driven on `num3..num0` in the digit order the display controller expects. It also sequences serve delay, play and game-over, and detects the winner. All outputs are registered so they can feed the display decoders directly.

---
 rtl/score_keeper.sv | 142 ++++++++++++++
 tb/tb_score_keeper.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// Pong score and rally-state keeper: BCD scores, serve delay, game over.
// All outputs are registered and feed the seven-segment decoders directly.
module score_keeper #(
    parameter int unsigned WIN_SCORE   = 11,
    parameter int unsigned SERVE_DELAY = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       point_left,
    input  logic       point_right,
    input  logic       new_game,
    output logic [3:0] num3,
    output logic [3:0] num2,
    output logic [3:0] num1,
    output logic [3:0] num0,
    output logic       serve_ready,
    output logic       game_over,
    output logic       winner
);

    localparam logic [3:0]  WIN_TENS = 4'(WIN_SCORE / 10);
    localparam logic [3:0]  WIN_ONES = 4'(WIN_SCORE % 10);
    localparam logic [31:0] RELOAD   = 32'(SERVE_DELAY - 1);

    typedef enum logic [1:0] {
        SERVE_WAIT = 2'd0,
        PLAY       = 2'd1,
        GAME_OVER  = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [31:0] cnt, cnt_n;
    logic [3:0]  lt_n, lo_n, rt_n, ro_n;
    logic [7:0]  l_inc, r_inc;
    logic        win_n;
    logic        pl_q, pr_q, ng_q;
    logic        ev_l, ev_r, ev_g;

    // 99 holds rather than wrapping; unreachable for legal WIN_SCORE
    function automatic logic [7:0] bcd_inc(input logic [3:0] t, input logic [3:0] o);
        if (t == 4'd9 && o == 4'd9)
            return {t, o};
        else if (o == 4'd9)
            return {t + 4'd1, 4'd0};
        else
            return {t, o + 4'd1};
    endfunction

    assign ev_l  = point_left  & ~pl_q;
    assign ev_r  = point_right & ~pr_q;
    assign ev_g  = new_game    & ~ng_q;
    assign l_inc = bcd_inc(num3, num2);
    assign r_inc = bcd_inc(num1, num0);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        lt_n    = num3;
        lo_n    = num2;
        rt_n    = num1;
        ro_n    = num0;
        win_n   = winner;
        if (ev_g) begin
            state_n = SERVE_WAIT;
            cnt_n   = RELOAD;
            lt_n    = 4'd0;
            lo_n    = 4'd0;
            rt_n    = 4'd0;
            ro_n    = 4'd0;
            win_n   = 1'b0;
        end else begin
            case (state)
                SERVE_WAIT: begin
                    if (cnt == 32'd0)
                        state_n = PLAY;
                    else
                        cnt_n = cnt - 32'd1;
                end
                PLAY: begin
                    if (ev_l && ev_r) begin
                        state_n = SERVE_WAIT;
                        cnt_n   = RELOAD;
                    end else if (ev_l) begin
                        {lt_n, lo_n} = l_inc;
                        if (l_inc == {WIN_TENS, WIN_ONES}) begin
                            state_n = GAME_OVER;
                            win_n   = 1'b0;
                        end else begin
                            state_n = SERVE_WAIT;
                            cnt_n   = RELOAD;
                        end
                    end else if (ev_r) begin
                        {rt_n, ro_n} = r_inc;
                        if (r_inc == {WIN_TENS, WIN_ONES}) begin
                            state_n = GAME_OVER;
                            win_n   = 1'b1;
                        end else begin
                            state_n = SERVE_WAIT;
                            cnt_n   = RELOAD;
                        end
                    end
                end
                GAME_OVER: ;
                default: begin
                    state_n = SERVE_WAIT;
                    cnt_n   = RELOAD;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= SERVE_WAIT;
            cnt         <= RELOAD;
            num3        <= 4'd0;
            num2        <= 4'd0;
            num1        <= 4'd0;
            num0        <= 4'd0;
            winner      <= 1'b0;
            serve_ready <= 1'b0;
            game_over   <= 1'b0;
            pl_q        <= 1'b0;
            pr_q        <= 1'b0;
            ng_q        <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            num3        <= lt_n;
            num2        <= lo_n;
            num1        <= rt_n;
            num0        <= ro_n;
            winner      <= win_n;
            serve_ready <= (state_n == PLAY);
            game_over   <= (state_n == GAME_OVER);
            pl_q        <= point_left;
            pr_q        <= point_right;
            ng_q        <= new_game;
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// Randomized bench for score_keeper against a point-counting game model.
// Scores are plain integers; the serve wait is a count of edges remaining.
module tb_score_keeper;

    localparam int WIN = 11;
    localparam int DLY = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       point_left = 1'b0;
    logic       point_right = 1'b0;
    logic       new_game = 1'b0;
    logic [3:0] num3, num2, num1, num0;
    logic       serve_ready, game_over, winner;

    int tests = 0;
    int fails = 0;

    // model: 0 = waiting to serve, 1 = rally, 2 = game finished
    int m_phase, m_left, m_wait, m_right;
    bit m_win, m_pl, m_pr, m_ng;

    score_keeper #(.WIN_SCORE(WIN), .SERVE_DELAY(DLY)) dut (
        .clk(clk), .rst(rst),
        .point_left(point_left), .point_right(point_right),
        .new_game(new_game),
        .num3(num3), .num2(num2), .num1(num1), .num0(num0),
        .serve_ready(serve_ready), .game_over(game_over),
        .winner(winner)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_wait = DLY; m_left = 0; m_right = 0;
        m_win = 0; m_pl = 0; m_pr = 0; m_ng = 0;
    endtask

    task automatic model_edge();
        bit el, er, eg;
        el = point_left && !m_pl;
        er = point_right && !m_pr;
        eg = new_game && !m_ng;
        m_pl = point_left; m_pr = point_right; m_ng = new_game;
        if (eg) begin
            m_left = 0; m_right = 0; m_win = 0;
            m_phase = 0; m_wait = DLY;
        end else if (m_phase == 0) begin
            m_wait--;
            if (m_wait == 0) m_phase = 1;
        end else if (m_phase == 1 && (el || er)) begin
            if (el && !er) m_left++;
            if (er && !el) m_right++;
            if (m_left == WIN || m_right == WIN) begin
                m_phase = 2;
                m_win = (m_right == WIN);
            end else begin
                m_phase = 0;
                m_wait = DLY;
            end
        end
    endtask

    task automatic check_all();
        check("num3", int'(num3), m_left / 10);
        check("num2", int'(num2), m_left % 10);
        check("num1", int'(num1), m_right / 10);
        check("num0", int'(num0), m_right % 10);
        check("serve_ready", int'(serve_ready), int'(m_phase == 1));
        check("game_over", int'(game_over), int'(m_phase == 2));
        check("winner", int'(winner), int'(m_win));
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) model_edge();
        #1;
        check_all();
    endtask

    // asserted between edges: outputs must clear without a clock
    task automatic pulse_reset();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        step();
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        #1;
        check_all();
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("ready_before_delay", int'(serve_ready), 0);
        step();
        check("ready_after_delay", int'(serve_ready), 1);

        point_left = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check("held_once", int'(num2), 1);
        point_left = 1'b0;
        step();

        for (int i = 0; i < 5; i++) step();
        point_left = 1'b1;
        point_right = 1'b1;
        step();
        check("replay_ready", int'(serve_ready), 0);
        point_left = 1'b0;
        point_right = 1'b0;

        for (int i = 0; i < 6000; i++) begin
            int r;
            r = int'($urandom_range(0, 999));
            if (r < 2) begin
                pulse_reset();
            end else begin
                if ($urandom_range(0, 3) == 0) point_left = ~point_left;
                if ($urandom_range(0, 3) == 0) point_right = ~point_right;
                if (!point_left && !point_right && $urandom_range(0, 7) == 0) begin
                    point_left = 1'b1;
                    point_right = 1'b1;
                end
                if ($urandom_range(0, 299) == 0) new_game = ~new_game;
                step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
